mc_mem_slave: RTL and testbench
===============================

# mc_mem_slave

Unified instruction/data memory responder for the multi-cycle MIPS core: it serves the core's single memory port, used for both instruction fetch and lw/sw, through a req/ready handshake with a configurable number of wait states. It sits between the core's memory-address mux and the on-chip word RAM. It flags misaligned or out-of-range accesses instead of performing them.

## Interface
- ADDR_W, 8: word-index width; the RAM holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states inserted before each valid access; legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  access request; level, sampled only in IDLE.
- we  input  1  1 = write (sw), 0 = read (fetch or lw); sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  write data; sampled with req.
- rdata  output  32  registered read data; holds until the next successful read.
- ready  output  1  one-cycle completion pulse, registered.
- err  output  1  error flag; valid only while ready=1, registered.
- busy  output  1  high whenever state != IDLE; decoded from the state register.

## Operation
- States: IDLE, WAIT, ACC. The state is encoded in 2 bits. The wait counter is 4 bits.
- IDLE with req=1: latch we, addr, wdata and a bad flag.
  - bad = (addr[1:0] != 0) OR (addr[31:ADDR_W+2] != 0).
  - bad=1, or WAIT_CYCLES=0: go to ACC.
  - Otherwise: go to WAIT with cnt = WAIT_CYCLES.
- WAIT: cnt decrements each edge. On the edge where cnt==1, go to ACC.
- ACC: on the next edge, return to IDLE and assert ready for exactly one cycle.
  - bad=1: err=1. No RAM write. rdata unchanged.
  - bad=0, we=1: mem[addr[ADDR_W+1:2]] <= latched wdata. err=0. rdata unchanged.
  - bad=0, we=0: rdata <= mem[addr[ADDR_W+1:2]]. err=0.
- req outside IDLE is ignored and not queued. Inputs that change during WAIT/ACC have no effect, because the latched copies are used.
- req=1 in the cycle ready=1 (state is IDLE) is accepted as a new request; this gives back-to-back accesses. The requester must drop req in the ready cycle if no further access is wanted.
- ready=0 and err=0 in every cycle other than the completion pulse.
- RAM contents are not reset and are undefined until written. The bench preloads the RAM through hierarchical access.

## Timing
- Reset values: state=IDLE, cnt=0, ready=0, err=0, busy=0, rdata=32'h0. Latched registers are cleared to 0.
- Latency, valid access: req sampled at edge N gives ready high in the cycle after edge N+WAIT_CYCLES+1. Write data is in the RAM at that same edge.
- Latency, bad access: ready and err high in the cycle after edge N+1, regardless of WAIT_CYCLES.
- busy rises after edge N and falls after the edge that raises ready. busy and ready are never high together.
- Reset mid-operation (WAIT or ACC): return to IDLE immediately. The pending write is discarded, the RAM is unchanged, and no ready pulse occurs.
- Address wrap: none. Any nonzero bit above ADDR_W+1 is an error, never aliased.
- Maximum throughput: one access per WAIT_CYCLES+2 cycles when req is held high.

## Test plan
- Default parameters. Write addr=0x0000_0010, wdata=0xDEAD_BEEF, then read the same address. Required:
  - each ready arrives 3 edges after req is sampled;
  - the read returns rdata=0xDEAD_BEEF;
  - err=0 on both accesses.
- Misaligned access: read at addr=0x0000_0012. Required: ready and err after 1 edge; rdata keeps its prior value; the RAM is unchanged.
- Out-of-range write: addr=0x0000_0400 with ADDR_W=8, then read word 0. Required: the write returns err=1; word 0 is not corrupted.
- Back-to-back: req held high for reads of 0x0, 0x4, 0x8 over preloaded values 1, 2, 3. Required: three ready pulses spaced 4 cycles apart, returning rdata 1, 2, 3 in order.
- Reset mid-WAIT: assert rst during the first WAIT cycle of a write of 0x1234_5678 to 0x20. Required:
  - all outputs return to their reset values immediately;
  - no ready pulse occurs;
  - a later read of 0x20 returns the old contents.
- WAIT_CYCLES=0 instance: a read is sampled at edge N. Required: ready after edge N+1; busy high for exactly one cycle.

Source files
------------

// File: rtl/mc_mem_slave.sv
// rtl/mc_mem_slave.sv - unified instruction/data memory responder with wait states and access checking
module mc_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t             state;
    state_t             state_next;
    logic [3:0]         cnt;
    logic               we_q;
    logic               bad_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               req_bad;
    logic [31:0]        mem [2**ADDR_W];

    // Upper address bits are never aliased onto the RAM; any of them set is an error.
    assign req_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_next = (req_bad || (WAIT_CYCLES == 0)) ? S_ACC : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_ACC;
                end
            end
            S_ACC:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata   <= 32'h0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        bad_q   <= req_bad;
                        idx_q   <= addr[ADDR_W+1:2];
                        wdata_q <= wdata;
                        cnt     <= WAIT_INIT;
                    end
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_ACC: begin
                    ready <= 1'b1;
                    err   <= bad_q;
                    if (!bad_q && !we_q) begin
                        rdata <= mem[idx_q];
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately not reset; an async reset forces IDLE so a pending write never lands.
    always_ff @(posedge clk) begin
        if (state == S_ACC && !bad_q && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mc_mem_slave.sv
// tb/tb_mc_mem_slave.sv - self-checking bench for mc_mem_slave with a word-array reference model
module tb_mc_mem_slave;

    localparam int AW    = 8;
    localparam int WAITS = 2;
    localparam int WORDS = 2**AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready, err, busy;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;

    logic [31:0] model_mem [WORDS];
    logic [31:0] model_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;

    mc_mem_slave #(.ADDR_W(AW), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    mc_mem_slave #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * WORDS);
    endfunction

    // One complete access on the WAIT_CYCLES=2 instance, checked against the model.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit bad;
        int edges;
        int idx;
        bad = is_bad(a);
        idx = int'((a / 4) % WORDS);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (!ready) check("busy_while_pending", {31'b0, busy}, 32'd1);
        end while (!ready && edges < 40);
        if (!bad) begin
            if (w) model_mem[idx] = d;
            else   model_rdata = model_mem[idx];
        end
        check("latency", edges, bad ? 32'd1 : 32'(WAITS + 1));
        check("err", {31'b0, err}, {31'b0, bad});
        check("rdata", rdata, model_rdata);
        check("busy_at_ready", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("ready_one_cycle", {31'b0, ready}, 32'd0);
        check("err_low_after", {31'b0, err}, 32'd0);
    endtask

    initial begin
        int k, cyc, prev, seen;
        logic [31:0] a;
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i] = $urandom;
            dut.mem[i]   = model_mem[i];
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_cnt", {28'b0, dut.cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0010, 32'h0);
        check("readback", rdata, 32'hDEAD_BEEF);

        access(1'b0, 32'h0000_0012, 32'h0);
        check("misaligned_ram", dut.mem[4], 32'hDEAD_BEEF);

        dut.mem[0] = 32'hCAFE_0000;
        model_mem[0] = 32'hCAFE_0000;
        access(1'b1, 32'h0000_0400, 32'hBAD0_BAD0);
        access(1'b0, 32'h0000_0000, 32'h0);
        check("word0_intact", rdata, 32'hCAFE_0000);

        for (int i = 0; i < 3; i++) begin
            dut.mem[i]   = 32'(i + 1);
            model_mem[i] = 32'(i + 1);
        end
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0;
        @(posedge clk); #1;
        k = 0; cyc = 0; prev = 0;
        while (k < 3 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (ready) begin
                k++;
                check("b2b_rdata", rdata, 32'(k));
                check("b2b_err", {31'b0, err}, 32'd0);
                check("b2b_spacing", cyc - prev, (k == 1) ? 32'(WAITS + 1) : 32'(WAITS + 2));
                prev = cyc;
                if (k < 3) addr = 32'(4 * k);
                else       req = 1'b0;
            end
        end
        check("b2b_count", k, 32'd3);
        model_rdata = 32'd3;
        repeat (2) @(posedge clk);

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        check("mid_wait_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("mid_rst_no_ready", seen, 32'd0);
        access(1'b0, 32'h20, 32'h0);
        check("mid_rst_old_data", rdata, model_mem[8]);

        dut0.mem[5] = 32'hA5A5_0005;
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h14;
        @(posedge clk); #1;
        req0 = 1'b0;
        check("w0_busy_first", {31'b0, busy0}, 32'd1);
        check("w0_ready_early", {31'b0, ready0}, 32'd0);
        @(posedge clk); #1;
        check("w0_ready", {31'b0, ready0}, 32'd1);
        check("w0_busy_done", {31'b0, busy0}, 32'd0);
        check("w0_err", {31'b0, err0}, 32'd0);
        check("w0_rdata", rdata0, 32'hA5A5_0005);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = {22'b0, 8'($urandom_range(0, WORDS - 1)), 2'b00};
                2:       a = {22'b0, 8'($urandom_range(0, WORDS - 1)), 2'($urandom_range(1, 3))};
                default: a = ($urandom & 32'hFFFF_FFFC) | (32'h1 << $urandom_range(10, 31));
            endcase
            access(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
